// File: rtl/pwm_duty_capture.sv
// Servo PWM capture: synchronise and deglitch pwm_in, then measure
// high time and rise-to-rise period in clk cycles with loss detection.
module pwm_duty_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER      = 4,
  parameter int unsigned DUTY_MIN    = 25_000,
  parameter int unsigned DUTY_MAX    = 125_000,
  parameter int unsigned PERIOD_MAX  = 1_100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [19:0] duty_out,
  output logic        duty_valid,
  output logic [20:0] period_out,
  output logic        range_err,
  output logic        signal_lost
);

  localparam int unsigned FW = $clog2(FILTER + 1);
  localparam logic [20:0] SETTLE = 21'(SYNC_STAGES + FILTER - 1);
  localparam logic [20:0] DMIN = 21'(DUTY_MIN);
  localparam logic [20:0] DMAX = 21'(DUTY_MAX);
  localparam logic [20:0] TMAX = 21'(PERIOD_MAX - 1);
  localparam logic [FW-1:0] FLAST = FW'(FILTER - 1);

  typedef enum logic [1:0] {
    SYNC,
    ARMED,
    HIGH,
    LOW
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic pwm_f_q, pwm_f_d;
  logic pwm_p_q;
  logic pwm_s;
  logic rise, fall, strobe;

  logic [20:0] hi_q, hi_d;
  logic [20:0] per_q, per_d;
  logic [20:0] to_q, to_d;
  logic [19:0] duty_q, duty_d;
  logic [20:0] period_q, period_d;
  logic dv_q, dv_d;
  logic re_q, re_d;
  logic lost_q, lost_d;

  function automatic logic [20:0] sat_inc(input logic [20:0] v);
    return (v == '1) ? v : v + 21'd1;
  endfunction

  assign pwm_s  = sync_q[SYNC_STAGES-1];
  assign rise   = pwm_f_q & ~pwm_p_q;
  assign fall   = ~pwm_f_q & pwm_p_q;
  assign strobe = rise | fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  // Level moves only on the FILTER-th agreeing sample, so both edges
  // see the same delay and widths survive unchanged.
  always_comb begin
    flt_cnt_d = '0;
    pwm_f_d   = pwm_f_q;
    if (pwm_s != pwm_f_q) begin
      if (flt_cnt_q == FLAST) begin
        pwm_f_d = pwm_s;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    per_d    = per_q;
    to_d     = to_q;
    duty_d   = duty_q;
    period_d = period_q;
    dv_d     = 1'b0;
    re_d     = 1'b0;
    lost_d   = lost_q;

    unique case (state_q)
      // Arm only once the whole front end has settled low; a pin
      // already high at reset must not look like a fresh rise.
      SYNC: begin
        if (!pwm_f_q && !pwm_s && flt_cnt_q == '0) begin
          if (to_q == SETTLE) begin
            state_d = ARMED;
            to_d    = '0;
          end else begin
            to_d = to_q + 21'd1;
          end
        end else begin
          to_d = '0;
        end
      end
      ARMED: begin
        if (rise) begin
          state_d = HIGH;
          hi_d    = 21'd1;
          per_d   = 21'd1;
        end
      end
      HIGH: begin
        hi_d  = sat_inc(hi_q);
        per_d = sat_inc(per_q);
        if (fall) begin
          state_d = LOW;
          if (hi_q >= DMIN && hi_q <= DMAX) begin
            duty_d = hi_q[19:0];
            dv_d   = 1'b1;
            lost_d = 1'b0;
          end else begin
            re_d = 1'b1;
          end
        end
      end
      LOW: begin
        per_d = sat_inc(per_q);
        if (rise) begin
          state_d  = HIGH;
          period_d = per_q;
          hi_d     = 21'd1;
          per_d    = 21'd1;
        end
      end
      default: state_d = SYNC;
    endcase

    if (state_q != SYNC) begin
      if (strobe) begin
        to_d = '0;
      end else if (to_q == TMAX) begin
        lost_d  = 1'b1;
        state_d = SYNC;
        to_d    = '0;
      end else begin
        to_d = to_q + 21'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      sync_q    <= '0;
      flt_cnt_q <= '0;
      pwm_f_q   <= 1'b0;
      pwm_p_q   <= 1'b0;
      hi_q      <= '0;
      per_q     <= '0;
      to_q      <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      dv_q      <= 1'b0;
      re_q      <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      flt_cnt_q <= flt_cnt_d;
      pwm_f_q   <= pwm_f_d;
      pwm_p_q   <= pwm_f_q;
      hi_q      <= hi_d;
      per_q     <= per_d;
      to_q      <= to_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      dv_q      <= dv_d;
      re_q      <= re_d;
      lost_q    <= lost_d;
    end
  end

  assign duty_out    = duty_q;
  assign duty_valid  = dv_q;
  assign period_out  = period_q;
  assign range_err   = re_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture with timing scaled by 1/1000.
// Scaled: duty 75 / period 1000, limits 25..125, timeout 1100.
module tb_pwm_duty_capture;

  logic        clk;
  logic        rst_n;
  logic        pwm_in;
  logic [19:0] duty_out;
  logic        duty_valid;
  logic [20:0] period_out;
  logic        range_err;
  logic        signal_lost;

  int n_chk;
  int n_err;
  int n_dv;
  int n_re;
  int dv0;
  int re0;

  pwm_duty_capture #(
    .SYNC_STAGES(2),
    .FILTER     (4),
    .DUTY_MIN   (25),
    .DUTY_MAX   (125),
    .PERIOD_MAX (1100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .period_out (period_out),
    .range_err  (range_err),
    .signal_lost(signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  always @(negedge clk) begin
    if (duty_valid) n_dv++;
    if (range_err) n_re++;
    if (duty_valid || range_err)
      chk("excl", int'(duty_valid & range_err), 0);
  end

  initial begin
    n_chk = 0; n_err = 0; n_dv = 0; n_re = 0;
    rst_n = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(duty_out), 0);
    chk("rst_period", int'(period_out), 0);
    chk("rst_dv", int'(duty_valid), 0);
    chk("rst_re", int'(range_err), 0);
    chk("rst_lost", int'(signal_lost), 0);
    rst_n = 1'b1;

    // 1: steady stream
    drive(1'b0, 100);
    pulse(75, 925);
    chk("t1_dv1", n_dv, 1);
    chk("t1_duty1", int'(duty_out), 75);
    chk("t1_per_first", int'(period_out), 0);
    pulse(75, 925);
    pulse(75, 925);
    chk("t1_dv3", n_dv, 3);
    chk("t1_duty", int'(duty_out), 75);
    chk("t1_period", int'(period_out), 1000);
    chk("t1_re", n_re, 0);

    // 2: sub-filter glitches in both phases
    drive(1'b1, 40);
    drive(1'b0, 3);
    drive(1'b1, 32);
    drive(1'b0, 400);
    drive(1'b1, 3);
    drive(1'b0, 522);
    chk("t2_dv", n_dv, 4);
    chk("t2_duty", int'(duty_out), 75);
    chk("t2_per_a", int'(period_out), 1000);
    pulse(75, 925);
    chk("t2_per_b", int'(period_out), 1000);
    chk("t2_dv2", n_dv, 5);
    chk("t2_re", n_re, 0);

    // 3: out-of-range widths
    pulse(10, 990);
    chk("t3_re_short", n_re, 1);
    pulse(130, 870);
    chk("t3_re_long", n_re, 2);
    chk("t3_dv", n_dv, 5);
    chk("t3_duty", int'(duty_out), 75);

    // 4: loss of signal
    drive(1'b1, 75);
    drive(1'b0, 1050);
    chk("t4_dv", n_dv, 6);
    chk("t4_not_lost", int'(signal_lost), 0);
    drive(1'b0, 100);
    chk("t4_lost", int'(signal_lost), 1);
    chk("t4_duty_hold", int'(duty_out), 75);
    chk("t4_per_hold", int'(period_out), 1000);
    pulse(50, 200);
    chk("t4_duty_new", int'(duty_out), 50);
    chk("t4_lost_clr", int'(signal_lost), 0);
    chk("t4_per_first", int'(period_out), 1000);
    chk("t4_dv2", n_dv, 7);

    // 5: input high across reset release
    pwm_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rst_duty", int'(duty_out), 0);
    rst_n = 1'b1;
    dv0 = n_dv; re0 = n_re;
    drive(1'b1, 40);
    drive(1'b0, 200);
    chk("t5_no_dv", n_dv - dv0, 0);
    chk("t5_no_re", n_re - re0, 0);
    pulse(60, 200);
    chk("t5_dv", n_dv - dv0, 1);
    chk("t5_duty", int'(duty_out), 60);

    // 6: async reset mid-pulse
    pulse(70, 930);
    pulse(70, 930);
    chk("t6_duty_pre", int'(duty_out), 70);
    chk("t6_per_pre", int'(period_out), 1000);
    drive(1'b1, 30);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_duty", int'(duty_out), 0);
    chk("t6_async_per", int'(period_out), 0);
    chk("t6_async_lost", int'(signal_lost), 0);
    drive(1'b1, 5);
    rst_n = 1'b1;
    dv0 = n_dv; re0 = n_re;
    drive(1'b1, 45);
    drive(1'b0, 200);
    chk("t6_no_dv", n_dv - dv0, 0);
    pulse(80, 200);
    chk("t6_dv", n_dv - dv0, 1);
    chk("t6_duty", int'(duty_out), 80);
    chk("t6_re", n_re - re0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
